// File: rtl/uncache_mmio_split.sv
// Routes LSU accesses to dcache or, for uncached windows, splits them into narrow
// arbiter beats and reassembles read data. Optional watchdog: UNCACHE_MMIO_TIMEOUT_EN.
module uncache_mmio_split #(
    parameter int DATA_W     = 64,
    parameter int BEAT_W     = 32,
    parameter int NUM_REGION = 4,
    parameter logic [NUM_REGION*64-1:0] REGION_BASE = {
        64'h0000_0000_0200_0000,   // CLINT
        64'h0000_0000_3000_0000,   // SPI
        64'h0000_0000_1000_1000,   // SPICTRL
        64'h0000_0000_1000_0000    // UART
    },
    parameter logic [NUM_REGION*64-1:0] REGION_END = {
        64'h0000_0000_0200_FFFF,
        64'h0000_0000_3FFF_FFFF,
        64'h0000_0000_1000_1FFF,
        64'h0000_0000_1000_0FFF
    },
    parameter int CLINT_IDX  = 3,
    parameter int TIMEOUT    = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [63:0]         core_addr,
    input  logic [DATA_W-1:0]   core_data,
    input  logic [DATA_W/8-1:0] core_mask,
    input  logic                core_we,
    input  logic                core_re,
    input  logic                fence_in,
    output logic [DATA_W-1:0]   in_core_data,
    output logic                in_core_finish,
    output logic                in_core_err,
    output logic [2:0]          mmio_sign,
    output logic [63:0]         dcache_addr,
    output logic [DATA_W-1:0]   dcache_data,
    output logic [DATA_W/8-1:0] dcache_mask,
    output logic                dcache_we,
    output logic                dcache_re,
    output logic                dcache_fence,
    input  logic [DATA_W-1:0]   in_dcache_data,
    input  logic                in_dcache_finish,
    output logic [63:0]         arb_addr,
    output logic [DATA_W-1:0]   arb_data,
    output logic [DATA_W/8-1:0] arb_mask,
    output logic                arb_we,
    output logic                arb_re,
    input  logic [DATA_W-1:0]   in_arb_data,
    input  logic                in_arb_finish,
    output logic [1:0]          dbg_state
);
    // Arbiter handshake: arb_re/arb_we is the valid, held with stable addr/data/mask
    // until in_arb_finish (the ready/response) is seen high at a clock edge.

    localparam int NBEAT = DATA_W / BEAT_W;
    localparam int BS    = BEAT_W / 8;
    localparam int MW    = DATA_W / 8;
    localparam int OFF_W = $clog2(MW);
    localparam int KW    = (NBEAT > 1) ? $clog2(NBEAT) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t             state_q, state_d;
    logic [KW-1:0]      k_q, k_d;
    logic [63:OFF_W]    addr_q;
    logic [DATA_W-1:0]  data_q;
    logic [MW-1:0]      mask_q;
    logic               we_q;
    logic               clint_q;
    logic [DATA_W-1:0]  asm_q;

    logic [NUM_REGION-1:0] region_hit;
    logic                  any_hit, clint_hit, req, start, cached;
    logic                  found, last_k, wd_fire;
    logic [KW-1:0]         first_k;
    logic [OFF_W-1:0]      beat_off;

    always_comb begin
        region_hit = '0;
        for (int r = 0; r < NUM_REGION; r++) begin
            region_hit[r] = (core_addr >= REGION_BASE[r*64 +: 64]) &&
                            (core_addr <= REGION_END[r*64 +: 64]);
        end
    end

    assign any_hit   = |region_hit;
    assign clint_hit = region_hit[CLINT_IDX];
    assign req       = core_re | core_we;
    assign start     = (state_q == IDLE) && req && any_hit;
    assign cached    = (state_q == IDLE) && !any_hit;

    // Lowest beat at or above k with a non-zero strobe slice; empty slices cost no cycles.
    always_comb begin
        found   = 1'b0;
        first_k = '0;
        for (int i = NBEAT - 1; i >= 0; i--) begin
            if ((i >= int'(k_q)) && (mask_q[i*BS +: BS] != '0)) begin
                found   = 1'b1;
                first_k = KW'(i);
            end
        end
    end

    assign last_k   = (k_q == KW'(NBEAT - 1));
    assign beat_off = OFF_W'(int'(k_q) * BS);

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ISSUE;
                    k_d     = '0;
                end
            end
            ISSUE: begin
                if (found) begin
                    state_d = WAIT;
                    k_d     = first_k;
                end else begin
                    state_d = DONE;
                end
            end
            WAIT: begin
                if (in_arb_finish) begin
                    if (last_k) begin
                        state_d = DONE;
                    end else begin
                        state_d = ISSUE;
                        k_d     = k_q + KW'(1);
                    end
                end else if (wd_fire) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            mask_q  <= '0;
            we_q    <= 1'b0;
            clint_q <= 1'b0;
            asm_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            if (start) begin
                addr_q  <= core_addr[63:OFF_W];
                data_q  <= core_data;
                mask_q  <= core_mask;
                we_q    <= core_we;
                clint_q <= clint_hit;
            end
            if ((state_q == WAIT) && in_arb_finish && !we_q) begin
                asm_q[k_q*BEAT_W +: BEAT_W] <= in_arb_data[BEAT_W-1:0];
            end else if (wd_fire) begin
                asm_q[k_q*BEAT_W +: BEAT_W] <= '1;
            end
            if (state_q == DONE) begin
                asm_q <= '0;
            end
        end
    end

`ifdef UNCACHE_MMIO_TIMEOUT_EN
    localparam int WD_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    logic [WD_W-1:0] wd_q;
    logic            err_q;

    // Fires in the TIMEOUT-th consecutive WAIT cycle without a beat completion.
    assign wd_fire = (state_q == WAIT) && !in_arb_finish && (wd_q == WD_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            if ((state_q == WAIT) && !in_arb_finish) begin
                wd_q <= wd_q + WD_W'(1);
            end else begin
                wd_q <= '0;
            end
            if (wd_fire) begin
                err_q <= 1'b1;
            end else if (state_q == DONE) begin
                err_q <= 1'b0;
            end
        end
    end

    assign in_core_err = (state_q == DONE) && err_q;
`else
    assign wd_fire     = 1'b0;
    assign in_core_err = 1'b0;
`endif

    logic unused_bits;
    assign unused_bits = ^{in_arb_data, 32'(TIMEOUT)};

    always_comb begin
        arb_re   = (state_q == WAIT) && !we_q;
        arb_we   = (state_q == WAIT) && we_q;
        arb_addr = '0;
        arb_data = '0;
        arb_mask = '0;
        if (state_q == WAIT) begin
            arb_addr = {addr_q, beat_off};
            arb_data = DATA_W'(data_q[k_q*BEAT_W +: BEAT_W]);
            arb_mask = MW'(mask_q[k_q*BS +: BS]);
        end
    end

    always_comb begin
        dcache_addr  = cached ? core_addr : '0;
        dcache_data  = cached ? core_data : '0;
        dcache_mask  = cached ? core_mask : '0;
        dcache_we    = cached && core_we;
        dcache_re    = cached && core_re;
        dcache_fence = fence_in;
    end

    always_comb begin
        in_core_data   = '0;
        in_core_finish = 1'b0;
        if (state_q == DONE) begin
            in_core_data   = asm_q;
            in_core_finish = 1'b1;
        end else if (cached) begin
            in_core_data   = in_dcache_data;
            in_core_finish = req && in_dcache_finish;
        end
    end

    // Once latched, the transaction's own region decides the sign, not the live address.
    always_comb begin
        if (!req) begin
            mmio_sign = 3'b000;
        end else if (state_q != IDLE) begin
            mmio_sign = clint_q ? 3'b010 : 3'b100;
        end else begin
            mmio_sign = clint_hit ? 3'b010 : 3'b100;
        end
    end

    assign dbg_state = state_q;

endmodule

// File: tb/tb_uncache_mmio_split.sv
// Directed bench for uncache_mmio_split: scoreboarded completions and arbiter beats.
module tb_uncache_mmio_split;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] core_addr;
    logic [63:0] core_data;
    logic [7:0]  core_mask;
    logic        core_we, core_re, fence_in;
    logic [63:0] in_core_data;
    logic        in_core_finish, in_core_err;
    logic [2:0]  mmio_sign;
    logic [63:0] dcache_addr, dcache_data;
    logic [7:0]  dcache_mask;
    logic        dcache_we, dcache_re, dcache_fence;
    logic [63:0] in_dcache_data;
    logic        in_dcache_finish;
    logic [63:0] arb_addr, arb_data;
    logic [7:0]  arb_mask;
    logic        arb_we, arb_re;
    logic [63:0] in_arb_data;
    logic        in_arb_finish;
    logic [1:0]  dbg_state;

    uncache_mmio_split dut (
        .clk(clk), .rst(rst),
        .core_addr(core_addr), .core_data(core_data), .core_mask(core_mask),
        .core_we(core_we), .core_re(core_re), .fence_in(fence_in),
        .in_core_data(in_core_data), .in_core_finish(in_core_finish),
        .in_core_err(in_core_err), .mmio_sign(mmio_sign),
        .dcache_addr(dcache_addr), .dcache_data(dcache_data), .dcache_mask(dcache_mask),
        .dcache_we(dcache_we), .dcache_re(dcache_re), .dcache_fence(dcache_fence),
        .in_dcache_data(in_dcache_data), .in_dcache_finish(in_dcache_finish),
        .arb_addr(arb_addr), .arb_data(arb_data), .arb_mask(arb_mask),
        .arb_we(arb_we), .arb_re(arb_re),
        .in_arb_data(in_arb_data), .in_arb_finish(in_arb_finish),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int finish_cnt = 0;
    int exp_fin = 0;
    int arb_cycles = 0;
    bit arb_stall = 1'b0;

    logic [63:0]  exp_q[$];       // expected in_core_data per completion
    logic [136:0] exp_beat_q[$];  // {we, addr, data, mask} per arbiter beat
    logic [31:0]  rd_q[$];        // arbiter read responses

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [136:0] mk_beat(input logic we, input logic [63:0] addr,
                                             input logic [63:0] data, input logic [7:0] mask);
        return {we, addr, data, mask};
    endfunction

    // Arbiter responder and scoreboard monitor.
    always @(negedge clk) begin
        logic [136:0] e;
        logic [63:0]  exp_d;
        if ((arb_re || arb_we) && !arb_stall) begin
            arb_cycles++;
            if (exp_beat_q.size() == 0) begin
                check("beat_unexpected", {arb_we, arb_re}, 2'b00);
            end else begin
                e = exp_beat_q.pop_front();
                check("beat_we",   arb_we,   e[136]);
                check("beat_addr", arb_addr, e[135:72]);
                check("beat_data", arb_data, e[71:8]);
                check("beat_mask", arb_mask, e[7:0]);
            end
            in_arb_finish = 1'b1;
            in_arb_data   = '0;
            if (arb_re) begin
                if (rd_q.size() == 0) check("rd_q_underflow", 1, 0);
                else in_arb_data = {32'h0, rd_q.pop_front()};
            end
        end else begin
            in_arb_finish = 1'b0;
            in_arb_data   = '0;
        end
        if (in_core_finish) begin
            finish_cnt++;
            check("core_err", in_core_err, 1'b0);
            if (exp_q.size() == 0) begin
                check("finish_unexpected", in_core_finish, 1'b0);
            end else begin
                exp_d = exp_q.pop_front();
                check("core_data", in_core_data, exp_d);
            end
        end
    end

    // Drives one uncached access and measures cycles from the request edge to finish.
    task automatic uncached(input string name, input logic [63:0] addr, input logic [63:0] data,
                            input logic [7:0] mask, input logic we, input int exp_lat,
                            input logic [2:0] exp_sign, input int exp_beats);
        int n;
        bit done;
        int a0, f0;
        a0 = arb_cycles;
        f0 = finish_cnt;
        @(posedge clk); #1;
        core_addr = addr; core_data = data; core_mask = mask;
        core_we = we; core_re = !we;
        n = 0;
        done = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            if (n == 0) begin
                check({name, "_sign"}, mmio_sign, exp_sign);
                check({name, "_dcache_off"}, {dcache_re, dcache_we, dcache_mask}, '0);
            end
            if (in_core_finish) done = 1;
            else n++;
        end
        check({name, "_latency"}, n, exp_lat);
        @(posedge clk); #1;
        core_re = 1'b0; core_we = 1'b0;
        check({name, "_beats"}, arb_cycles - a0, exp_beats);
        check({name, "_one_finish"}, finish_cnt - f0, 1);
    endtask

    task automatic probe_cached(input string name, input logic [63:0] addr);
        @(posedge clk); #1;
        core_addr = addr; core_mask = 8'hFF; core_re = 1'b1;
        @(negedge clk);
        check({name, "_dcache"}, {dcache_re, arb_re, dcache_addr}, {2'b10, addr});
        check({name, "_sign"}, mmio_sign, 3'b100);
        @(posedge clk); #1;
        core_re = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1'b1;
        core_addr = '0; core_data = '0; core_mask = '0;
        core_we = 0; core_re = 0; fence_in = 0;
        in_dcache_data = '0; in_dcache_finish = 0;
        in_arb_data = '0; in_arb_finish = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_arb", {arb_re, arb_we, arb_addr, arb_mask}, '0);
        check("reset_core", {in_core_finish, in_core_err, in_core_data}, '0);
        check("reset_sign", mmio_sign, 3'b000);
        check("reset_state", dbg_state, 2'd0);
        fence_in = 1'b1;
        #1 check("fence_fwd", dcache_fence, 1'b1);
        fence_in = 1'b0;

        // Cached read, dcache answers on the fourth request cycle.
        exp_q.push_back(64'h0123_4567_89AB_CDEF); exp_fin++;
        @(posedge clk); #1;
        core_addr = 64'h8000_0000; core_mask = 8'hFF; core_re = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("cached_path", {dcache_re, arb_re, arb_we, dcache_addr}, {3'b100, 64'h8000_0000});
            check("cached_sign", mmio_sign, 3'b100);
            check("cached_state", dbg_state, 2'd0);
            @(posedge clk); #1;
        end
        in_dcache_data = 64'h0123_4567_89AB_CDEF; in_dcache_finish = 1'b1;
        @(posedge clk); #1;
        in_dcache_finish = 1'b0; in_dcache_data = '0; core_re = 1'b0;

        // Two-beat UART read.
        exp_beat_q.push_back(mk_beat(0, 64'h1000_0000, 64'h0, 8'h0F));
        exp_beat_q.push_back(mk_beat(0, 64'h1000_0004, 64'h0, 8'h0F));
        rd_q.push_back(32'h1122_3344); rd_q.push_back(32'h5566_7788);
        exp_q.push_back(64'h5566_7788_1122_3344); exp_fin++;
        uncached("uart_rd", 64'h1000_0000, 64'h0, 8'hFF, 1'b0, 5, 3'b100, 2);

        // CLINT write, low beat skipped.
        exp_beat_q.push_back(mk_beat(1, 64'h0200_4004, 64'h0000_0000_AAAA_BBBB, 8'h0F));
        exp_q.push_back(64'h0); exp_fin++;
        uncached("clint_wr", 64'h0200_4000, 64'hAAAA_BBBB_CCCC_DDDD, 8'hF0, 1'b1, 3, 3'b010, 1);

        // All-zero mask: no beats.
        exp_q.push_back(64'h0); exp_fin++;
        uncached("zero_mask", 64'h3000_0010, 64'h0, 8'h00, 1'b0, 2, 3'b100, 0);

        // Low beat only; skipped high lane reads 0.
        exp_beat_q.push_back(mk_beat(0, 64'h1000_0008, 64'h0, 8'h0F));
        rd_q.push_back(32'hDEAD_BEEF);
        exp_q.push_back(64'h0000_0000_DEAD_BEEF); exp_fin++;
        uncached("low_only", 64'h1000_0008, 64'h0, 8'h0F, 1'b0, 4, 3'b100, 1);

        // Inclusive CLINT end address.
        exp_beat_q.push_back(mk_beat(0, 64'h0200_FFFC, 64'h0, 8'h0F));
        rd_q.push_back(32'h600D_CAFE);
        exp_q.push_back(64'h600D_CAFE_0000_0000); exp_fin++;
        uncached("clint_end", 64'h0200_FFFF, 64'h0, 8'hF0, 1'b0, 3, 3'b010, 1);

        probe_cached("below_uart", 64'h0FFF_FFFF);
        probe_cached("above_clint", 64'h0201_0000);

        // Reset while beat 0 is waiting on the arbiter.
        arb_stall = 1'b1;
        @(posedge clk); #1;
        core_addr = 64'h1000_0000; core_mask = 8'hFF; core_re = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!arb_re && n < 20);
        check("rst_wait_reached", arb_re, 1'b1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;
        check("rst_arb_drop", {arb_re, arb_we}, 2'b00);
        check("rst_state", dbg_state, 2'd0);
        check("rst_no_finish", in_core_finish, 1'b0);
        rst = 1'b0; core_re = 1'b0; arb_stall = 1'b0;

        exp_beat_q.push_back(mk_beat(0, 64'h1000_0000, 64'h0, 8'h0F));
        exp_beat_q.push_back(mk_beat(0, 64'h1000_0004, 64'h0, 8'h0F));
        rd_q.push_back(32'hCAFE_F00D); rd_q.push_back(32'h0BAD_F00D);
        exp_q.push_back(64'h0BAD_F00D_CAFE_F00D); exp_fin++;
        uncached("post_rst_rd", 64'h1000_0000, 64'h0, 8'hFF, 1'b0, 5, 3'b100, 2);

        repeat (3) @(posedge clk);
        check("exp_q_drained", exp_q.size(), 0);
        check("beat_q_drained", exp_beat_q.size(), 0);
        check("rd_q_drained", rd_q.size(), 0);
        check("finish_total", finish_cnt, exp_fin);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uncache_mmio_split.md
Name: uncache_mmio_split

Overview:
- Registered successor to the combinational uncache router between the LSU and the data path.
- Decodes each core access against NUM_REGION parametrised uncached windows.
- Cached accesses pass to dcache unchanged. Uncached accesses are split into DATA_W/BEAT_W narrow beats on the arbiter port, sequenced by an FSM.
- Read beats are reassembled and a single completion pulse is returned to the core.

Parameters:
- DATA_W, 64, core data width.
- BEAT_W, 32, uncached bus beat width; must divide DATA_W; power of two, at least 8.
- NUM_REGION, 4, number of uncached address windows.
- REGION_BASE, {UART,SPICTRL,SPI,CLINT starts}, NUM_REGION×64 concatenated inclusive lower bounds; region 0 in LSBs.
- REGION_END, {matching ends}, NUM_REGION×64 inclusive upper bounds.
- CLINT_IDX, 3, region index reported as CLINT on mmio_sign.
- TIMEOUT, 255, watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- core_addr  in  64  access address.
- core_data  in  DATA_W  write data.
- core_mask  in  DATA_W/8  byte strobes.
- core_we  in  1  write request, level, held until in_core_finish.
- core_re  in  1  read request, level, held until in_core_finish.
- fence_in  in  1  fence, forwarded.
- in_core_data  out  DATA_W  read data.
- in_core_finish  out  1  one-cycle completion pulse.
- in_core_err  out  1  one-cycle error pulse, coincident with in_core_finish.
- mmio_sign  out  3  010 = CLINT access, 100 = other active access, 000 = idle.
- dcache_addr/data/mask/we/re/fence  out  64/DATA_W/DATA_W/8/1/1/1  cached path.
- in_dcache_data  in  DATA_W;  in_dcache_finish  in  1.
- arb_addr  out  64;  arb_data  out  DATA_W;  arb_mask  out  DATA_W/8;  arb_we  out  1;  arb_re  out  1.
- in_arb_data  in  DATA_W;  in_arb_finish  in  1  one-cycle beat completion.

Behaviour:
- Region hit: base ≤ core_addr ≤ end, inclusive, for any region. Decode is combinational, but is sampled only in IDLE.
- Reset: FSM = IDLE, beat counter 0, assembly register 0. All arb_* and in_core_* outputs are 0; mmio_sign = 000.
- Cached access (no region hit): dcache_* follow core_* combinationally, including in IDLE. in_core_data/finish come from the dcache. The FSM stays in IDLE and arb_* stay 0. dcache_fence = fence_in at all times.
- Uncached access: dcache_we/re/mask/addr/data are 0 for its whole duration.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE → ISSUE on (core_re|core_we) with a region hit. Latches addr, data, mask and direction; beat counter k = 0.
- ISSUE: evaluates beat k.
  - Mask slice k = mask[(k+1)*BEAT_W/8-1 : k*BEAT_W/8].
  - If the slice is zero, the beat is skipped without any bus request; k increments, or the FSM goes to DONE if k was last.
  - Otherwise → WAIT.
- WAIT: arb_re or arb_we = 1, held until in_arb_finish.
  - arb_addr = {addr[63:3], k*BEAT_W/8}, i.e. low beat first, ascending.
  - arb_data = latched data slice k, placed at bits [BEAT_W-1:0]; upper bits 0.
  - arb_mask = slice k in the LSBs.
  - On in_arb_finish (reads): assembly[k*BEAT_W +: BEAT_W] = in_arb_data[BEAT_W-1:0].
  - Next state: ISSUE with k+1, or DONE if k is last.
  - In the cycle after finish, arb_re/arb_we are 0 (at least one idle cycle between beats).
- DONE: one cycle with in_core_finish = 1 and in_core_data = assembly (skipped beats read 0). Then → IDLE, assembly cleared.
- Minimum latency for 2 beats with finish the same cycle as request: 1 (issue) + 2×1 (wait) + 1 (issue) + 1 (done) = 5 cycles from the request edge.
- The core must hold its request until finish; the FSM ignores core_* changes after latching.
  - A request still asserted in the cycle after DONE starts a new transaction. The LSU drops re/we on finish.
- All-zero mask on an uncached access: no beats issued; finish pulse 1 cycle after ISSUE.
- Reset mid-transaction: immediate return to IDLE. No finish pulse. Any in-flight arb request drops the next cycle.
- mmio_sign: 010 if the region hit is CLINT_IDX; 100 for any other active access (cached or uncached); 000 when core_re = core_we = 0.
- in_core_err = 0 always unless the optional feature is enabled.

Optional Feature:
- Macro: UNCACHE_MMIO_TIMEOUT_EN.
- Defined:
  - An 8+ bit watchdog counts cycles spent in WAIT, clearing on each in_arb_finish.
  - When it reaches TIMEOUT, the current beat is abandoned: arb_re/arb_we drop and the beat lane reads all-ones.
  - The FSM goes directly to DONE; in_core_err pulses with in_core_finish.
- Undefined: no counter logic; WAIT holds indefinitely; in_core_err tied 0.

Test Plan:
- Cached read at 0x8000_0000 with dcache finish after 3 cycles → dcache_re = 1, arb_re = 0 throughout; in_core_data = dcache data; mmio_sign = 100.
- Uncached read at UART base 0x1000_0000, mask 0xFF; arbiter returns 0x11223344 then 0x55667788 → beats at 0x1000_0000 then 0x1000_0004; in_core_data = 0x55667788_11223344; exactly one finish pulse.
- Uncached write at CLINT 0x0200_4000, data 0xAAAA_BBBB_CCCC_DDDD, mask 0xF0 → single beat at 0x0200_4004 with arb_data = 0xAAAABBBB, arb_mask = 0xF; low beat skipped; mmio_sign = 010.
- Uncached access with mask 0x00 → zero arb requests; finish asserted 2 cycles after the request.
- rst asserted during WAIT of beat 0 → next cycle arb_re = 0, FSM in IDLE, no finish pulse; a fresh read afterwards completes normally.
- With UNCACHE_MMIO_TIMEOUT_EN and TIMEOUT = 16, arbiter never finishes → after 16 WAIT cycles: finish and err pulse together, in_core_data lane 0 = 0xFFFFFFFF.
